simple_computer: RTL and testbench
==================================

Name: simple_computer

Overview:
- Single-cycle 32-bit toy processor.
- Executes a program supplied as a flat 1024-bit vector, i.e. 32 instruction words.
- Contains a 16x32 register file, an ALU (add/sub/mul/div/shift/logic), a 16x32 data RAM and a 5-bit PC.
- Top of the small computer design; a debug port exposes architectural state to the bench.

Parameters:
- XLEN, 32, datapath width.
- NREG, 16, register count (r0 reads as zero).
- DMEM_WORDS, 16, data RAM depth.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears PC, registers, RAM, halted.
- code  input  1024  program ROM image; word i = code[32*i+31 : 32*i], sampled combinationally each cycle.
- dbg_sel  input  4  register index for debug read.
- dbg_data  output  32  combinational value of register dbg_sel (0 for r0).
- pc  output  5  current program counter.
- halted  output  1  high once HALT has executed.

Behaviour:
- Reset (synchronous, high at a rising edge):
  - pc=0, halted=0, all registers and RAM words=0.
  - Reset has priority over instruction execution; applying it mid-program aborts the program and restarts at 0.
- Fetch: instr = code word[pc].
- Format: op[31:28], rd[27:24], rs1[23:20], rs2[19:16], imm[15:0].
- Execution: one instruction per cycle. Results written at the rising edge. Default next pc = pc+1, wrapping 31->0.
- Opcodes:
  - 0 NOP.
  - 1 ADD rd=rs1+rs2.
  - 2 SUB rd=rs1-rs2.
  - 3 MUL rd=low 32 bits of rs1*rs2, unsigned.
  - 4 DIV rd=rs1/rs2 unsigned; divisor 0 gives 0xFFFFFFFF.
  - 5 SHL rd=rs1<<rs2[4:0].
  - 6 SHR rd=rs1>>rs2[4:0] logical.
  - 7 ADDI rd=rs1+zero-extended imm.
  - 8 LD rd=RAM[(rs1+imm)[3:0]].
  - 9 ST RAM[(rs1+imm)[3:0]]=reg[rd].
  - A JMP pc=imm[4:0].
  - B BEQ if reg[rd]==reg[rs1], pc=imm[4:0], else pc+1.
  - C AND. D OR. E XOR (rd=rs1 op rs2).
  - F HALT.
- Writes to r0 are discarded. All arithmetic is modulo 2^32 and sets no flags.
- HALT: halted=1; pc and all state frozen until reset. While halted, code changes have no effect.
- Reading and writing the same register in one instruction uses the old value; the new value is visible next cycle.
- LD after ST to the same address in the next cycle returns the stored value (RAM written at the edge, read combinationally).
- Changes to code are legal at any time and affect the instruction fetched that cycle.

Optional Feature:
- Macro SIMPLE_COMPUTER_MULDIV_EN.
- Defined: opcodes 3 and 4 behave as above.
- Undefined: no multiplier or divider is built; opcodes 3 and 4 execute as NOP (rd unchanged, pc+1).

Decomposition:
- Shared package simple_computer_pkg:
  - opcode localparams (OP_NOP..OP_HALT);
  - field bit positions;
  - XLEN/NREG/DMEM_WORDS defaults;
  - instruction-field struct typedef.
- One natural sub-module: exec_unit, a combinational ALU taking op, a, b, imm and returning the result; it contains the MUL/DIV guarded by the macro.
- Register file, RAM and PC stay in the top module.

Test Plan:
- Arithmetic: program 0x71000005, 0x72000003, 0x13120000, 0x24210000, 0xF0000000 -> after halt r1=5, r2=3, r3=8, r4=0xFFFFFFFE, pc=4, halted=1.
- Mul/div (macro on): r1=5, r2=3 then 0x35120000, 0x46120000, 0x47100000 -> r5=15, r6=1, r7=0xFFFFFFFF. With the macro off, r5, r6 and r7 stay 0.
- Memory: r3=8, then 0x93000002, 0x87000002 -> r7=8; 0x8800000F (LD from untouched word 15) -> r8=0.
- Control: 0x71000001, 0xB1100004 (BEQ r1==r1 -> pc=4), word 4 = 0xA0000000 (JMP 0) loops; pc sequence 0,1,4,0,1,4. Also an all-NOP program wraps pc 31->0.
- r0 / shifts: 0x70000009 leaves r0=0. r1=1, r2=31: SHL 0x53120000 -> r3=0x80000000; SHR 0x64320000 -> r4=1.
- Reset mid-run: assert reset for one cycle during the arithmetic program -> next cycle pc=0, all registers 0, halted=0; the program reruns to the same final values.

Source files
------------

// File: rtl/simple_computer_pkg.sv
// Shared definitions for the simple_computer toy processor: opcodes, field layout, sizes.
// Optional MUL/DIV support is enabled with the SIMPLE_COMPUTER_MULDIV_EN macro.
package simple_computer_pkg;

    localparam int XLEN_DEF       = 32;
    localparam int NREG_DEF       = 16;
    localparam int DMEM_WORDS_DEF = 16;
    localparam int IMEM_WORDS     = 32;
    localparam int PC_W           = 5;

    localparam int OP_MSB  = 31;
    localparam int OP_LSB  = 28;
    localparam int RD_MSB  = 27;
    localparam int RD_LSB  = 24;
    localparam int RS1_MSB = 23;
    localparam int RS1_LSB = 20;
    localparam int RS2_MSB = 19;
    localparam int RS2_LSB = 16;
    localparam int IMM_MSB = 15;
    localparam int IMM_LSB = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_DIV  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_LD   = 4'h8;
    localparam logic [3:0] OP_ST   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_AND  = 4'hC;
    localparam logic [3:0] OP_OR   = 4'hD;
    localparam logic [3:0] OP_XOR  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef struct packed {
        logic [OP_MSB-OP_LSB:0]   op;
        logic [RD_MSB-RD_LSB:0]   rd;
        logic [RS1_MSB-RS1_LSB:0] rs1;
        logic [RS2_MSB-RS2_LSB:0] rs2;
        logic [IMM_MSB-IMM_LSB:0] imm;
    } instr_t;

endpackage

// File: rtl/simple_computer_exec_unit.sv
// Combinational ALU: computes the write-back value (or LD/ST address) and whether rd is written.
// MUL/DIV hardware exists only when SIMPLE_COMPUTER_MULDIV_EN is defined.
module exec_unit
    import simple_computer_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [15:0]     imm,
    output logic [XLEN-1:0] result,
    output logic            wb
);

    logic [XLEN-1:0] imm_ext;

    assign imm_ext = {{(XLEN-16){1'b0}}, imm};

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        result = '0;
        wb     = 1'b0;
        unique case (op)
            OP_ADD:  begin result = a + b;          wb = 1'b1; end
            OP_SUB:  begin result = a - b;          wb = 1'b1; end
`ifdef SIMPLE_COMPUTER_MULDIV_EN
            OP_MUL:  begin result = a * b;          wb = 1'b1; end
            OP_DIV:  begin
                result = (b == '0) ? '1 : a / b;
                wb     = 1'b1;
            end
`endif
            OP_SHL:  begin result = a << b[4:0];    wb = 1'b1; end
            OP_SHR:  begin result = a >> b[4:0];    wb = 1'b1; end
            OP_ADDI: begin result = a + imm_ext;    wb = 1'b1; end
            // LD/ST: result carries the effective address; top decides write-back data.
            OP_LD:   begin result = a + imm_ext;    wb = 1'b1; end
            OP_ST:   begin result = a + imm_ext;    wb = 1'b0; end
            OP_AND:  begin result = a & b;          wb = 1'b1; end
            OP_OR:   begin result = a | b;          wb = 1'b1; end
            OP_XOR:  begin result = a ^ b;          wb = 1'b1; end
            default: begin result = '0;             wb = 1'b0; end
        endcase
    end

endmodule

// File: rtl/simple_computer.sv
// Single-cycle 32-bit toy processor: fetch from the code vector, execute, write back each clock.
// Opcodes 3/4 (MUL/DIV) are real only when SIMPLE_COMPUTER_MULDIV_EN is defined; otherwise NOP.
module simple_computer
    import simple_computer_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int NREG       = NREG_DEF,
    parameter int DMEM_WORDS = DMEM_WORDS_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [IMEM_WORDS*32-1:0]      code,
    input  logic [3:0]                    dbg_sel,
    output logic [XLEN-1:0]               dbg_data,
    output logic [PC_W-1:0]               pc,
    output logic                          halted
);

    logic [XLEN-1:0] regs [NREG];
    logic [XLEN-1:0] dmem [DMEM_WORDS];

    instr_t          ins;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] alu_result;
    logic            alu_wb;
    logic [3:0]      mem_addr;
    logic [XLEN-1:0] wb_data;
    logic [PC_W-1:0] pc_next;

    function automatic logic [XLEN-1:0] read_reg(input logic [3:0] idx);
        return (idx == 4'd0) ? '0 : regs[idx];
    endfunction

    assign ins      = instr_t'(code[{pc, 5'd0} +: 32]);
    assign rd_val   = read_reg(ins.rd);
    assign rs1_val  = read_reg(ins.rs1);
    assign rs2_val  = read_reg(ins.rs2);
    assign dbg_data = read_reg(dbg_sel);

    exec_unit #(.XLEN(XLEN)) u_exec (
        .op     (ins.op),
        .a      (rs1_val),
        .b      (rs2_val),
        .imm    (ins.imm),
        .result (alu_result),
        .wb     (alu_wb)
    );

    assign mem_addr = alu_result[3:0];
    assign wb_data  = (ins.op == OP_LD) ? dmem[mem_addr] : alu_result;

    always_comb begin
        pc_next = pc + 5'd1;
        unique case (ins.op)
            OP_JMP:  pc_next = ins.imm[4:0];
            OP_BEQ:  if (rd_val == rs1_val) pc_next = ins.imm[4:0];
            OP_HALT: pc_next = pc;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc     <= '0;
            halted <= 1'b0;
            // NOTE: register file and data RAM are architecturally cleared by reset, so they are
            // built from resettable flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            for (int i = 0; i < DMEM_WORDS; i++) dmem[i] <= '0;
        end else if (!halted) begin
            // NOTE: non-blocking updates make every read in this cycle see pre-edge state.
            pc <= pc_next;
            if (ins.op == OP_HALT) halted <= 1'b1;
            if (alu_wb && ins.rd != 4'd0) regs[ins.rd] <= wb_data;
            if (ins.op == OP_ST) dmem[mem_addr] <= rd_val;
        end
    end

endmodule

// File: tb/tb_simple_computer.sv
// Directed self-checking bench for simple_computer: arithmetic, mul/div, memory, control,
// shifts, halt freeze and mid-run reset, with hand-computed expectations.
module tb_simple_computer;

    logic          clk = 1'b0;
    logic          reset;
    logic [1023:0] code;
    logic [3:0]    dbg_sel;
    logic [31:0]   dbg_data;
    logic [4:0]    pc;
    logic          halted;

    int total = 0;
    int bad   = 0;

    simple_computer dut (
        .clk      (clk),
        .reset    (reset),
        .code     (code),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data),
        .pc       (pc),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] idx, input logic [31:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic set_word(input int i, input logic [31:0] w);
        code[32*i +: 32] = w;
    endtask

    // One rising edge with reset high; returns on the following falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_to_halt(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (halted === 1'b1) break;
            @(negedge clk);
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    logic [4:0] exp_pc [6];

    initial begin
        reset   = 1'b1;
        code    = '0;
        dbg_sel = '0;
        exp_pc  = '{5'd0, 5'd1, 5'd4, 5'd0, 5'd1, 5'd4};

        // Arithmetic
        set_word(0, 32'h71000005);
        set_word(1, 32'h72000003);
        set_word(2, 32'h13120000);
        set_word(3, 32'h24210000);
        set_word(4, 32'hF0000000);
        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check_reg("rst_r1", 4'd1, 32'd0);
        run_to_halt("arith_halt");
        check_reg("arith_r1", 4'd1, 32'd5);
        check_reg("arith_r2", 4'd2, 32'd3);
        check_reg("arith_r3", 4'd3, 32'd8);
        check_reg("arith_r4", 4'd4, 32'hFFFFFFFE);
        check("arith_pc", 32'(pc), 32'd4);

        // Halted state ignores new code
        for (int i = 0; i < 32; i++) set_word(i, 32'h71000007);
        repeat (3) @(negedge clk);
        check("frozen_pc", 32'(pc), 32'd4);
        check("frozen_halted", 32'(halted), 32'd1);
        check_reg("frozen_r1", 4'd1, 32'd5);

        // Reset mid-run, then rerun
        code = '0;
        set_word(0, 32'h71000005);
        set_word(1, 32'h72000003);
        set_word(2, 32'h13120000);
        set_word(3, 32'h24210000);
        set_word(4, 32'hF0000000);
        do_reset();
        repeat (2) @(negedge clk);
        check("mid_pc_before", 32'(pc), 32'd2);
        check_reg("mid_r1_before", 4'd1, 32'd5);
        do_reset();
        check("mid_pc", 32'(pc), 32'd0);
        check("mid_halted", 32'(halted), 32'd0);
        check_reg("mid_r1", 4'd1, 32'd0);
        check_reg("mid_r2", 4'd2, 32'd0);
        run_to_halt("mid_halt");
        check_reg("mid_r3", 4'd3, 32'd8);
        check_reg("mid_r4", 4'd4, 32'hFFFFFFFE);

        // Mul/div
        code = '0;
        set_word(0, 32'h71000005);
        set_word(1, 32'h72000003);
        set_word(2, 32'h35120000);
        set_word(3, 32'h46120000);
        set_word(4, 32'h47100000);
        set_word(5, 32'hF0000000);
        do_reset();
        run_to_halt("md_halt");
        check("md_pc", 32'(pc), 32'd5);
`ifdef SIMPLE_COMPUTER_MULDIV_EN
        check_reg("md_r5", 4'd5, 32'd15);
        check_reg("md_r6", 4'd6, 32'd1);
        check_reg("md_r7", 4'd7, 32'hFFFFFFFF);
`else
        check_reg("md_r5", 4'd5, 32'd0);
        check_reg("md_r6", 4'd6, 32'd0);
        check_reg("md_r7", 4'd7, 32'd0);
`endif

        // Memory: ST then LD next cycle, untouched word, BEQ not taken
        code = '0;
        set_word(0, 32'h73000008);
        set_word(1, 32'h93000002);
        set_word(2, 32'h87000002);
        set_word(3, 32'h8800000F);
        set_word(4, 32'hB7800010);
        set_word(5, 32'hF0000000);
        do_reset();
        run_to_halt("mem_halt");
        check_reg("mem_r7", 4'd7, 32'd8);
        check_reg("mem_r8", 4'd8, 32'd0);
        check("mem_pc", 32'(pc), 32'd5);

        // RAM cleared by reset
        code = '0;
        set_word(0, 32'h87000002);
        set_word(1, 32'hF0000000);
        do_reset();
        run_to_halt("ramrst_halt");
        check_reg("ramrst_r7", 4'd7, 32'd0);

        // Control: taken BEQ and JMP loop
        code = '0;
        set_word(0, 32'h71000001);
        set_word(1, 32'hB1100004);
        set_word(4, 32'hA0000000);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ctl_pc%0d", i), 32'(pc), 32'(exp_pc[i]));
            @(negedge clk);
        end

        // All-NOP program wraps 31 -> 0
        code = '0;
        do_reset();
        repeat (31) @(negedge clk);
        check("wrap_pc31", 32'(pc), 32'd31);
        @(negedge clk);
        check("wrap_pc0", 32'(pc), 32'd0);

        // r0 and shifts
        code = '0;
        set_word(0, 32'h70000009);
        set_word(1, 32'h71000001);
        set_word(2, 32'h7200001F);
        set_word(3, 32'h53120000);
        set_word(4, 32'h64320000);
        set_word(5, 32'h15000000);
        set_word(6, 32'hF0000000);
        do_reset();
        run_to_halt("sh_halt");
        check_reg("sh_r0", 4'd0, 32'd0);
        check_reg("sh_r3", 4'd3, 32'h80000000);
        check_reg("sh_r4", 4'd4, 32'd1);
        check_reg("sh_r5_from_r0", 4'd5, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
